// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - two-channel arbiter feeding a registered 2:1 mux output stage (option: RR_FAIRNESS_EN)
module rr_mux_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             A_valid,
    input  logic [WIDTH-1:0] A,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [WIDTH-1:0] B,
    output logic             B_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Y_valid,
    input  logic             Y_ready,
    output logic             Sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   load;
    logic   grant_a;
    logic   grant_b;

    assign Y_valid = (state == FULL);
    assign load    = !Y_valid || Y_ready;
    assign A_ready = load && grant_a;
    assign B_ready = load && grant_b;

`ifdef RR_FAIRNESS_EN
    // last_win = 1 means B won the most recent transfer; resets to B so A wins first contention
    logic last_win;

    // Round-robin grant: on contention the channel that did not win last time is served
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (A_valid && B_valid) begin
            grant_a = last_win;
            grant_b = !last_win;
        end else begin
            grant_a = A_valid;
            grant_b = B_valid;
        end
    end

    // Remember the winner of every accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win <= 1'b1;
        end else if (load && (grant_a || grant_b)) begin
            last_win <= grant_b;
        end
    end
`else
    // Fixed priority: A always wins contention
    always_comb begin
        grant_a = A_valid;
        grant_b = B_valid && !A_valid;
    end
`endif

    // Output state: fill on any accepted word, empty when loading with nothing granted
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = (grant_a || grant_b) ? FULL : EMPTY;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output data and select; both hold whenever nothing is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y   <= '0;
            Sel <= 1'b0;
        end else if (load) begin
            if (grant_a) begin
                Y   <= A;
                Sel <= 1'b0;
            end else if (grant_b) begin
                Y   <= B;
                Sel <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             A_valid;
    logic [WIDTH-1:0] A;
    logic             A_ready;
    logic             B_valid;
    logic [WIDTH-1:0] B;
    logic             B_ready;
    logic [WIDTH-1:0] Y;
    logic             Y_valid;
    logic             Y_ready;
    logic             Sel;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A_valid (A_valid),
        .A       (A),
        .A_ready (A_ready),
        .B_valid (B_valid),
        .B       (B),
        .B_ready (B_ready),
        .Y       (Y),
        .Y_valid (Y_valid),
        .Y_ready (Y_ready),
        .Sel     (Sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_y [4];
    logic       exp_s [4];

    initial begin
`ifdef RR_FAIRNESS_EN
        exp_y[0] = 8'h11; exp_y[1] = 8'h22; exp_y[2] = 8'h11; exp_y[3] = 8'h22;
        exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;
`else
        exp_y[0] = 8'h11; exp_y[1] = 8'h11; exp_y[2] = 8'h11; exp_y[3] = 8'h11;
        exp_s[0] = 1'b0;  exp_s[1] = 1'b0;  exp_s[2] = 1'b0;  exp_s[3] = 1'b0;
`endif
        rst_n   = 1'b1;
        A_valid = 1'b1;
        A       = 8'h11;
        B_valid = 1'b1;
        B       = 8'h22;
        Y_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;

        // reset state with both inputs valid
        chk("rst_yvalid", Y_valid, 0);
        chk("rst_y", Y, 0);
        chk("rst_sel", Sel, 0);
        chk("rst_a_ready", A_ready, 1);
        chk("rst_b_ready", B_ready, 0);
        step();
        chk("rst_hold_yvalid", Y_valid, 0);

        // release between edges; first edge captures A
        #5 rst_n = 1'b1;
        step();
        chk("first_y", Y, 8'h11);
        chk("first_sel", Sel, 0);
        chk("first_yvalid", Y_valid, 1);

        // single channel B
        A_valid = 1'b0;
        B_valid = 1'b1;
        B       = 8'h5A;
        Y_ready = 1'b1;
        #1;
        chk("single_b_ready", B_ready, 1);
        chk("single_a_ready", A_ready, 0);
        step();
        chk("single_y", Y, 8'h5A);
        chk("single_sel", Sel, 1);
        chk("single_yvalid", Y_valid, 1);

        // contention for four cycles
        A_valid = 1'b1;
        A       = 8'h11;
        B_valid = 1'b1;
        B       = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_not_both_ready", {31'd0, A_ready && B_ready}, 0);
            step();
            chk($sformatf("cont_y%0d", i), Y, exp_y[i]);
            chk($sformatf("cont_sel%0d", i), Sel, exp_s[i]);
        end

        // backpressure: hold 33 while A offers 44
        A_valid = 1'b1;
        A       = 8'h33;
        B_valid = 1'b0;
        Y_ready = 1'b1;
        step();
        chk("bp_load_y", Y, 8'h33);
        Y_ready = 1'b0;
        A       = 8'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_a_ready%0d", i), A_ready, 0);
            step();
            chk($sformatf("bp_y%0d", i), Y, 8'h33);
            chk($sformatf("bp_yvalid%0d", i), Y_valid, 1);
        end
        Y_ready = 1'b1;
        #1;
        chk("bp_release_a_ready", A_ready, 1);
        step();
        chk("bp_release_y", Y, 8'h44);
        chk("bp_release_sel", Sel, 0);

        // load from B then drain
        A_valid = 1'b0;
        B_valid = 1'b1;
        B       = 8'h66;
        step();
        chk("pre_drain_sel", Sel, 1);
        B_valid = 1'b0;
        step();
        chk("drain_yvalid", Y_valid, 0);
        chk("drain_sel", Sel, 1);
        chk("drain_y", Y, 8'h66);
        step();
        chk("idle_yvalid", Y_valid, 0);
        chk("idle_a_ready", A_ready, 0);
        chk("idle_b_ready", B_ready, 0);

        // async reset mid-stream
        A_valid = 1'b1;
        A       = 8'h11;
        B_valid = 1'b1;
        B       = 8'h22;
        step();
        chk("mid_y0", Y, 8'h11);
        step();
        chk("mid_yvalid", Y_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_yvalid", Y_valid, 0);
        chk("mid_rst_y", Y, 0);
        chk("mid_rst_sel", Sel, 0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_y", Y, 8'h11);
        chk("post_rst_sel", Sel, 0);
        step();
`ifdef RR_FAIRNESS_EN
        chk("post_rst_y2", Y, 8'h22);
`else
        chk("post_rst_y2", Y, 8'h11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
